alu_operand_loader: RTL and testbench

//   Front-end stage feeding the 2-bit ALU / 7-segment datapath. It synchronises the raw operand and opcode

---
 rtl/alu_operand_loader.sv | 139 +++++++++++++
 tb/tb_alu_operand_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand loader: synchronises switches, debounces LOAD, captures {A,B,OP}
// and hands the word to the ALU over a valid/ready handshake.
module alu_operand_loader #(
    parameter int DEB_CYCLES = 1000,
    parameter int DEB_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_load,
    input  logic [1:0] sw_a,
    input  logic [1:0] sw_b,
    input  logic [1:0] sw_op,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] out_a,
    output logic [1:0] out_b,
    output logic [1:0] out_op,
    output logic       busy,
    output logic [3:0] drop_cnt
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_btn_s1, r_btn_s2;
    logic [1:0]       r_a_s1, r_a_s2;
    logic [1:0]       r_b_s1, r_b_s2;
    logic [1:0]       r_op_s1, r_op_s2;
    logic             r_db, r_db_prev;
    logic [DEB_W-1:0] r_cnt;
    state_t           r_state, w_next;
    logic             w_press, w_load, w_drop;
    logic [1:0]       r_a, r_b, r_op;
    logic [3:0]       r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_a_s1   <= '0;
            r_a_s2   <= '0;
            r_b_s1   <= '0;
            r_b_s2   <= '0;
            r_op_s1  <= '0;
            r_op_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_load;
            r_btn_s2 <= r_btn_s1;
            r_a_s1   <= sw_a;
            r_a_s2   <= r_a_s1;
            r_b_s1   <= sw_b;
            r_b_s2   <= r_b_s1;
            r_op_s1  <= sw_op;
            r_op_s2  <= r_op_s1;
        end
    end

    // db only follows the button after DEB_CYCLES straight cycles of disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_db_prev <= r_db;
            if (r_btn_s2 != r_db) begin
                if (r_cnt == DEB_LAST) begin
                    r_db  <= r_btn_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign w_press = r_db & ~r_db_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_drop = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_load = 1'b1;
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_drop = w_press;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_drop <= '0;
        end else begin
            if (w_load) begin
                r_a  <= r_a_s2;
                r_b  <= r_b_s2;
                r_op <= r_op_s2;
            end
            if (w_drop && (r_drop != 4'hF)) begin
                r_drop <= r_drop + 4'd1;
            end
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_HOLD);
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_op    = r_op;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: cycle model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_alu_operand_loader;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_load = 1'b0;
    logic [1:0] sw_a = '0;
    logic [1:0] sw_b = '0;
    logic [1:0] sw_op = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_a, out_b, out_op;
    logic       busy;
    logic [3:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    alu_operand_loader #(.DEB_CYCLES(DEB), .DEB_W(4)) dut (
        .clk(clk), .rst(rst), .btn_load(btn_load),
        .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: raw inputs delayed two edges, a run of DEB
    // mismatched samples flips the clean level, rising clean edge = press.
    logic       m_btn1 = 0, m_btn2 = 0;
    logic [1:0] m_a1 = 0, m_a2 = 0, m_b1 = 0, m_b2 = 0, m_o1 = 0, m_o2 = 0;
    logic       m_db = 0, m_dbp = 0, m_hold = 0;
    int         m_run = 0;
    logic [1:0] m_a = 0, m_b = 0, m_op = 0;
    int         m_drop = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_btn1 = 0; m_btn2 = 0;
            m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0; m_o1 = 0; m_o2 = 0;
            m_db = 0; m_dbp = 0; m_hold = 0; m_run = 0;
            m_a = 0; m_b = 0; m_op = 0; m_drop = 0;
        end else begin
            logic press;
            press = m_db && !m_dbp;
            if (m_hold) begin
                if (press && m_drop < 15) m_drop++;
                if (out_ready) m_hold = 0;
            end else if (press) begin
                m_a = m_a2; m_b = m_b2; m_op = m_o2;
                m_hold = 1;
            end
            m_dbp = m_db;
            if (m_btn2 != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db = m_btn2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_btn2 = m_btn1; m_btn1 = btn_load;
            m_a2 = m_a1; m_a1 = sw_a;
            m_b2 = m_b1; m_b1 = sw_b;
            m_o2 = m_o1; m_o1 = sw_op;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cycle", {20'd0, out_valid, busy, out_a, out_b, out_op, drop_cnt},
                {20'd0, m_hold, m_hold, m_a, m_b, m_op, m_drop[3:0]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_once();
        btn_load = 1'b1;
        cyc(8);
        btn_load = 1'b0;
        cyc(8);
    endtask

    initial begin
        bit seen;
        #1 rst = 1'b1;
        sw_a = 2'b10; sw_b = 2'b01; sw_op = 2'b00;
        #2 rst = 1'b0;
        btn_load = 1'b1;
        started = 1;

        // 1: capture latency
        chk("reset_valid", out_valid, 0);
        chk("reset_drop", drop_cnt, 0);
        cyc(6);
        chk("t1_valid_edge6", out_valid, 0);
        cyc(1);
        chk("t1_valid_edge7", out_valid, 1);
        chk("t1_a", out_a, 2);
        chk("t1_b", out_b, 1);
        chk("t1_op", out_op, 0);
        chk("t1_busy", busy, 1);

        // 2: accept, button still held
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("t2_valid_accept", out_valid, 0);
        cyc(10);
        chk("t2_no_recapture", out_valid, 0);
        btn_load = 1'b0;
        cyc(10);

        // 3: short glitches
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            btn_load = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                seen |= out_valid;
            end
            btn_load = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                seen |= out_valid;
            end
        end
        chk("t3_never_valid", seen, 0);
        chk("t3_drop", drop_cnt, 0);

        // 4: drops saturate
        sw_a = 2'b01; sw_b = 2'b10; sw_op = 2'b11;
        cyc(3);
        press_once();
        chk("t4_valid", out_valid, 1);
        chk("t4_a0", out_a, 1);
        for (int i = 0; i < 17; i++) press_once();
        chk("t4_drop_sat", drop_cnt, 15);
        chk("t4_a", out_a, 1);
        chk("t4_b", out_b, 2);
        chk("t4_op", out_op, 3);

        // 5: switches ignored in HOLD
        sw_a = 2'b11;
        cyc(5);
        chk("t5_a_frozen", out_a, 1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("t5_accepted", out_valid, 0);
        press_once();
        chk("t5_valid", out_valid, 1);
        chk("t5_a_new", out_a, 3);

        // 6: async reset mid-HOLD
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_word", {out_a, out_b, out_op}, 0);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
